// File: rtl/multi_holder_pkg.sv
// Shared definitions for the multi-channel pulse stretcher.
//   IDLE / HOLD : per-channel FSM state encoding
//   MIN_HOLD    : shortest hold length; a hold_time of 0 is raised to this
package multi_holder_pkg;

  localparam logic IDLE = 1'b0;
  localparam logic HOLD = 1'b1;

  localparam int unsigned MIN_HOLD = 1;

endpackage

// File: rtl/multi_holder_if.sv
// Bus bundle between the game-control logic and the pulse stretcher.
//   clr        : synchronous abort of all channels
//   hold_time  : hold length in cycles, sampled on each accepted trigger
//   signal_in  : per-channel request
//   signal_out : per-channel stretched output
//   expired    : per-channel one-cycle timeout strobe
// master drives the requests, slave (the stretcher) drives the outputs.
interface multi_holder_if #(
  parameter int CHANNELS  = 4,
  parameter int CNT_WIDTH = 26
);

  logic                 clr;
  logic [CNT_WIDTH-1:0] hold_time;
  logic [CHANNELS-1:0]  signal_in;
  logic [CHANNELS-1:0]  signal_out;
  logic [CHANNELS-1:0]  expired;

  modport master (
    output clr, hold_time, signal_in,
    input  signal_out, expired
  );

  modport slave (
    input  clr, hold_time, signal_in,
    output signal_out, expired
  );

endinterface

// File: rtl/multi_holder_channel.sv
// One pulse-stretcher channel: trigger detection, IDLE/HOLD FSM,
// hold counter and expiry strobe.
//   clk, rst   : clock, synchronous active-high reset
//   clr        : synchronous abort (no expiry strobe)
//   hold_time  : hold length, 0 treated as 1
//   signal_in  : request input
//   signal_out : registered stretched output
//   expired    : high in the cycle signal_out falls on timeout
module holder_channel
  import multi_holder_pkg::*;
#(
  parameter int CNT_WIDTH = 26,
  parameter int RETRIGGER = 1,
  parameter int EDGE_MODE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic [CNT_WIDTH-1:0] hold_time,
  input  logic                 signal_in,
  output logic                 signal_out,
  output logic                 expired
);

  // Counter reload value: the count runs from H-1 down to 0, giving H
  // high cycles. hold_time below the minimum is saturated up to it.
  function automatic logic [CNT_WIDTH-1:0] hold_reload(input logic [CNT_WIDTH-1:0] ht);
    logic [CNT_WIDTH-1:0] h;
    h = (ht < CNT_WIDTH'(MIN_HOLD)) ? CNT_WIDTH'(MIN_HOLD) : ht;
    return h - CNT_WIDTH'(1);
  endfunction

  logic                 state;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 in_d;
  logic                 trig;

  // in_d resets to 0, so an input already high after reset is an edge.
  assign trig = (EDGE_MODE != 0) ? (signal_in & ~in_d) : signal_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      in_d       <= 1'b0;
      signal_out <= 1'b0;
      expired    <= 1'b0;
    end else begin
      // in_d keeps tracking during clr, so an edge coinciding with clr is lost.
      in_d    <= signal_in;
      expired <= 1'b0;
      if (clr) begin
        state      <= IDLE;
        cnt        <= '0;
        signal_out <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (trig) begin
              cnt        <= hold_reload(hold_time);
              state      <= HOLD;
              signal_out <= 1'b1;
            end else begin
              signal_out <= 1'b0;
            end
          end
          default: begin
            // Retrigger takes priority over expiry in the same cycle.
            if ((RETRIGGER != 0) && trig) begin
              cnt <= hold_reload(hold_time);
            end else if (cnt == '0) begin
              state      <= IDLE;
              signal_out <= 1'b0;
              expired    <= 1'b1;
            end else begin
              cnt <= cnt - CNT_WIDTH'(1);
            end
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/multi_holder.sv
// Multi-channel pulse stretcher for the game-control path.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of multi_holder_if (clr, hold_time, signal_in in;
//              signal_out, expired out)
// clk, rst, clr and hold_time are broadcast to CHANNELS independent channels.
module multi_holder
  import multi_holder_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int CNT_WIDTH = 26,
  parameter int RETRIGGER = 1,
  parameter int EDGE_MODE = 0
) (
  input  logic          clk,
  input  logic          rst,
  multi_holder_if.slave bus
);

  logic [CHANNELS-1:0] out_w;
  logic [CHANNELS-1:0] exp_w;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    holder_channel #(
      .CNT_WIDTH (CNT_WIDTH),
      .RETRIGGER (RETRIGGER),
      .EDGE_MODE (EDGE_MODE)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .clr        (bus.clr),
      .hold_time  (bus.hold_time),
      .signal_in  (bus.signal_in[i]),
      .signal_out (out_w[i]),
      .expired    (exp_w[i])
    );
  end

  assign bus.signal_out = out_w;
  assign bus.expired    = exp_w;

endmodule

// File: tb/tb_multi_holder.sv
// Scoreboard bench for multi_holder. Three instances cover the mode
// combinations: a = retrigger/level, b = one-shot/level, c = retrigger/edge.
// Each test fills per-cycle stimulus and hand-computed expected tables;
// the driver pushes the expected outputs for each cycle into a queue and
// a negedge monitor pops and compares them against the selected instance.
module tb_multi_holder;

  localparam int CH = 4;
  localparam int CW = 26;
  localparam int TN = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic [CW-1:0] hold = '0;
  logic [CH-1:0] sig = '0;

  always #5 clk = ~clk;

  multi_holder_if #(.CHANNELS(CH), .CNT_WIDTH(CW)) if_a ();
  multi_holder_if #(.CHANNELS(CH), .CNT_WIDTH(CW)) if_b ();
  multi_holder_if #(.CHANNELS(CH), .CNT_WIDTH(CW)) if_c ();

  assign if_a.clr = clr;  assign if_a.hold_time = hold;  assign if_a.signal_in = sig;
  assign if_b.clr = clr;  assign if_b.hold_time = hold;  assign if_b.signal_in = sig;
  assign if_c.clr = clr;  assign if_c.hold_time = hold;  assign if_c.signal_in = sig;

  multi_holder #(.CHANNELS(CH), .CNT_WIDTH(CW), .RETRIGGER(1), .EDGE_MODE(0))
    dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  multi_holder #(.CHANNELS(CH), .CNT_WIDTH(CW), .RETRIGGER(0), .EDGE_MODE(0))
    dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
  multi_holder #(.CHANNELS(CH), .CNT_WIDTH(CW), .RETRIGGER(1), .EDGE_MODE(1))
    dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));

  typedef struct {
    int            tnum;
    int            cyc;
    int            sel;
    logic [CH-1:0] out;
    logic [CH-1:0] xp;
  } exp_t;

  exp_t scb[$];

  int n_tests = 0;
  int n_fail  = 0;

  // stimulus and expected-waveform tables, indexed by cycle
  logic [CH-1:0] sig_t  [TN];
  logic          clr_t  [TN];
  logic          rst_t  [TN];
  logic [CW-1:0] hold_t [TN];
  logic [CH-1:0] eo_t   [TN];
  logic [CH-1:0] ex_t   [TN];

  task automatic clear_tabs();
    for (int c = 0; c < TN; c++) begin
      sig_t[c] = '0; clr_t[c] = 1'b0; rst_t[c] = 1'b0;
      hold_t[c] = '0; eo_t[c] = '0; ex_t[c] = '0;
    end
  endtask

  task automatic set_hold(input int from, input logic [CW-1:0] v);
    for (int c = from; c < TN; c++) hold_t[c] = v;
  endtask

  task automatic set_sig(input int ch, input int a, input int b);
    for (int c = a; c <= b; c++) sig_t[c][ch] = 1'b1;
  endtask

  task automatic set_out(input int ch, input int a, input int b);
    for (int c = a; c <= b; c++) eo_t[c][ch] = 1'b1;
  endtask

  task automatic set_exp(input int ch, input int c);
    ex_t[c][ch] = 1'b1;
  endtask

  // Reset for two edges, then play the tables: inputs for cycle c are
  // applied just after the edge that starts cycle c.
  task automatic run(input int tnum, input int sel, input int n);
    exp_t e;
    rst = 1'b1; clr = 1'b0; sig = '0; hold = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int c = 0; c < n; c++) begin
      rst = rst_t[c]; clr = clr_t[c]; sig = sig_t[c]; hold = hold_t[c];
      e.tnum = tnum; e.cyc = c; e.sel = sel; e.out = eo_t[c]; e.xp = ex_t[c];
      scb.push_back(e);
      @(posedge clk);
      #1;
    end
    sig = '0; clr = 1'b0;
    clear_tabs();
  endtask

  logic [CH-1:0] mon_out, mon_xp;

  always @(negedge clk) begin
    if (scb.size() > 0) begin
      exp_t e;
      e = scb.pop_front();
      case (e.sel)
        0:       begin mon_out = if_a.signal_out; mon_xp = if_a.expired; end
        1:       begin mon_out = if_b.signal_out; mon_xp = if_b.expired; end
        default: begin mon_out = if_c.signal_out; mon_xp = if_c.expired; end
      endcase
      n_tests++;
      if (mon_out !== e.out || mon_xp !== e.xp) begin
        n_fail++;
        $display("FAIL t%0d cyc%0d dut%0d: signal_out=%b want %b, expired=%b want %b",
                 e.tnum, e.cyc, e.sel, mon_out, e.out, mon_xp, e.xp);
      end
    end
  end

  initial begin
    clear_tabs();

    // 1: basic stretch, hold 5, pulse ch0 at 10
    set_hold(0, 26'd5); set_sig(0, 10, 10);
    set_out(0, 11, 15); set_exp(0, 16);
    run(1, 0, 22);

    // 2: retrigger at 13 extends to 18
    set_hold(0, 26'd5); set_sig(0, 10, 10); set_sig(0, 13, 13);
    set_out(0, 11, 18); set_exp(0, 19);
    run(2, 0, 24);

    // 3: same stimulus one-shot, second pulse ignored
    set_hold(0, 26'd5); set_sig(0, 10, 10); set_sig(0, 13, 13);
    set_out(0, 11, 15); set_exp(0, 16);
    run(3, 1, 24);

    // 4: edge mode, ch2 held high 5..40, single pulse
    set_hold(0, 26'd3); set_sig(2, 5, 40);
    set_out(2, 6, 8); set_exp(2, 9);
    run(4, 2, 45);

    // 5: edge mode, input high while rst deasserts
    set_hold(0, 26'd3); rst_t[0] = 1'b1; set_sig(2, 0, 11);
    set_out(2, 2, 4); set_exp(2, 5);
    run(5, 2, 12);

    // 6: hold_time 0 acts as 1
    set_hold(0, 26'd0); set_sig(1, 10, 10);
    set_out(1, 11, 11); set_exp(1, 12);
    run(6, 0, 16);

    // 7: hold_time 8 -> 2 mid-hold
    set_hold(0, 26'd8); set_hold(8, 26'd2);
    set_sig(0, 5, 5); set_sig(0, 20, 20);
    set_out(0, 6, 13); set_exp(0, 14);
    set_out(0, 21, 22); set_exp(0, 23);
    run(7, 0, 26);

    // 8: clr mid-hold, then trigger coinciding with clr
    set_hold(0, 26'd5); set_sig(0, 10, 10); clr_t[13] = 1'b1;
    set_sig(0, 20, 20); clr_t[20] = 1'b1;
    set_out(0, 11, 13);
    run(8, 0, 26);

    // 9: rst mid-hold
    set_hold(0, 26'd5); set_sig(3, 4, 4); rst_t[7] = 1'b1;
    set_out(3, 5, 7);
    run(9, 0, 14);

    // 10: level one-shot, continuous input: 4 high, 1 low
    set_hold(0, 26'd4); set_sig(3, 0, 15);
    set_out(3, 1, 4);   set_exp(3, 5);
    set_out(3, 6, 9);   set_exp(3, 10);
    set_out(3, 11, 14); set_exp(3, 15);
    run(10, 1, 16);

    // 11: all channels triggered together
    set_hold(0, 26'd2); sig_t[3] = 4'hF;
    for (int ch = 0; ch < CH; ch++) begin
      set_out(ch, 4, 5); set_exp(ch, 6);
    end
    run(11, 0, 9);

    // 12: continuous level with retrigger stays high, then H more cycles
    set_hold(0, 26'd3); set_sig(1, 2, 7);
    set_out(1, 3, 10); set_exp(1, 11);
    run(12, 0, 14);

    @(posedge clk);
    #1;
    if (scb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", scb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
